amba_axi4_lite_adder_ctrl: RTL and testbench
============================================

Name: amba_axi4_lite_adder_ctrl

Overview:
- AXI4-Lite slave front-end that sequences the multi-cycle adder core.
- Handles independent AW/W arrival, the B and AR/R channels, and a small register map (operands, control, status, result).
- Issues single-cycle start pulses to the adder core and captures its sum and carry on completion.
- Sits between the system AXI4-Lite bus and the adder datapath.

Parameters:
- SIZE_WORD, 32, data width of the bus and of each adder operand.
- SIZE_STRB, SIZE_WORD/8, write-strobe width.
- SIZE_ADDR, 32, address width; only ADDR[4:2] is decoded.

Ports:
- ACLK  in  1  clock.
- ARSTn  in  1  asynchronous active-low reset.
- AWVALID/AWREADY  in/out  1/1  write-address handshake.
- AWADDR  in  SIZE_ADDR  write address.
- AWPROT  in  3  ignored.
- WVALID/WREADY  in/out  1/1  write-data handshake.
- WDATA  in  SIZE_WORD  write data.
- WSTRB  in  SIZE_STRB  byte strobes.
- BVALID/BREADY  out/in  1/1  write-response handshake.
- BRESP  out  2  axi4_resp_el.
- ARVALID/ARREADY  in/out  1/1  read-address handshake.
- ARADDR  in  SIZE_ADDR  read address.
- ARPROT  in  3  ignored.
- RVALID/RREADY  out/in  1/1  read-data handshake.
- RDATA  out  SIZE_WORD  read data.
- RRESP  out  2  axi4_resp_el.
- add_start  out  1  one-cycle start pulse to the adder core.
- add_a, add_b  out  SIZE_WORD  operands, held stable while busy.
- add_done  in  1  one-cycle completion pulse from the core.
- add_sum  in  SIZE_WORD  sum, valid with add_done.
- add_carry  in  1  carry-out, valid with add_done.

Behaviour:
- Reset values (ARSTn low, asynchronous): all VALID/READY outputs 0, BRESP/RRESP OKAY, RDATA 0, add_start 0, OP_A/OP_B/RESULT 0, STATUS 0, FSMs in IDLE.
- Register map (ADDR[4:2]):
  - 0: OP_A, RW.
  - 1: OP_B, RW.
  - 2: CTRL, WO; bit0 START, self-clearing, reads 0.
  - 3: STATUS, RO; bit0 busy, bit1 done (sticky), bit2 carry.
  - 4: RESULT, RO.
  - 5-7: unmapped, SLVERR.
- Write path:
  - AW and W are captured independently into holding registers with held flags.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - The cycle both are held: perform the write, assert BVALID on the next edge, clear both held flags.
  - BVALID and BRESP stay stable until BREADY; BVALID deasserts on the BVALID&&BREADY edge.
  - AW and W arriving in the same cycle give BVALID one cycle later.
- Write rules:
  - OP_A/OP_B are written bytewise per WSTRB.
  - START needs WSTRB[0]=1 and WDATA[0]=1; otherwise the CTRL write is a no-op with OKAY.
  - SLVERR with no state change for: a write to STATUS/RESULT/unmapped, a write to OP_A/OP_B while busy, or START while busy.
- Read path:
  - ARREADY = !RVALID.
  - After an AR handshake, RDATA/RRESP are registered and RVALID asserts next cycle, held until RREADY.
  - An unmapped read gives RDATA 0 and SLVERR.
- Concurrent read and write: the two paths are fully independent. A read issued in the same cycle as a write returns pre-write register values.
- Sequencer FSM:
  - C_IDLE: an accepted START drives add_start=1 for exactly one cycle, sets busy, clears done, and moves to C_RUN.
  - C_RUN: on add_done, capture add_sum into RESULT and add_carry into STATUS.carry, set done, clear busy, return to C_IDLE.
  - add_done while in C_IDLE is ignored.
  - add_a/add_b are driven continuously from OP_A/OP_B; they cannot change while busy because such writes are rejected.
- Reset mid-operation: all state returns to reset values immediately. Any pending B/R response is dropped, and the core's later add_done is ignored.

Optional Feature:
- Macro ADDER_CTRL_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, reset 0).
  - CTRL bit1 becomes the RW interrupt-enable IE.
  - irq = done && IE, registered.
  - done is cleared by a write of 1 to STATUS bit1 (W1C, OKAY) as well as by START.
- When undefined:
  - No irq port.
  - CTRL bit1 is ignored.
  - STATUS writes return SLVERR.

Decomposition:
- Package amba_axi4_lite_types_pkg (shared) holds:
  - axi4_resp_el {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - Register index localparams ADDER_REG_OP_A..ADDER_REG_RESULT.
  - STATUS bit-position constants.
  - Sequencer state enum.
- One sub-module, axi4_lite_wr_capture: AW/W holding registers plus the B handshake. The read path and sequencer stay in the top.

Test Plan:
- Write OP_A=0xFFFF_FFFF and OP_B=0x0000_0002 with AW and W in the same cycle, then write CTRL=1; model the core to pulse add_done 4 cycles after add_start with sum 0x1 and carry 1 -> add_start is high for exactly 1 cycle, each B returns OKAY 1 cycle after capture, STATUS reads 0x6, RESULT reads 0x0000_0001.
- W issued 3 cycles before AW -> WREADY drops after capture, BVALID is asserted 1 cycle after the AW handshake, OP_B is updated.
- Write OP_A with WSTRB=4'b0010 and WDATA=0xAABB_CCDD over 0x1122_3344 -> OP_A reads 0x1122_CC44.
- START while busy, and an OP_A write while busy -> both return SLVERR, OP_A is unchanged, exactly one add_start pulse in total.
- Read from 0x1C and write to RESULT -> both return SLVERR, RDATA 0; with BREADY held low for 5 cycles, BVALID and BRESP stay stable throughout.
- Assert ARSTn low while in C_RUN with BVALID pending -> all outputs return to reset values asynchronously, and a later add_done leaves RESULT at 0.

Source files
------------

// File: rtl/amba_axi4_lite_types_pkg.sv
// Shared AXI4-Lite types and adder-controller register map constants.
//
// Contents:
//   axi4_resp_el        - AXI response encoding (OKAY/EXOKAY/SLVERR/DECERR)
//   ADDER_REG_*         - register indices, decoded from ADDR[4:2]
//   STATUS_BIT_*        - bit positions inside the STATUS register
//   CTRL_BIT_*          - bit positions inside the CTRL register
//   adder_seq_state_e   - sequencer states driving the adder core
package amba_axi4_lite_types_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4_resp_el;

  localparam logic [2:0] ADDER_REG_OP_A   = 3'd0;
  localparam logic [2:0] ADDER_REG_OP_B   = 3'd1;
  localparam logic [2:0] ADDER_REG_CTRL   = 3'd2;
  localparam logic [2:0] ADDER_REG_STATUS = 3'd3;
  localparam logic [2:0] ADDER_REG_RESULT = 3'd4;

  localparam int STATUS_BIT_BUSY  = 0;
  localparam int STATUS_BIT_DONE  = 1;
  localparam int STATUS_BIT_CARRY = 2;

  localparam int CTRL_BIT_START = 0;
  localparam int CTRL_BIT_IE    = 1;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } adder_seq_state_e;

endpackage

// File: rtl/axi4_lite_wr_capture.sv
// AXI4-Lite write-channel capture: holds AW and W independently until both
// have arrived, presents one write request to the register file for a single
// cycle, then returns the response on B and holds it until BREADY.
//
// Ports:
//   ACLK, ARSTn                 clock, asynchronous active-low reset
//   accept_en                   low for the first cycle after reset; blocks READY
//   AWVALID/AWREADY/AWADDR      write-address channel (ADDR[4:2] kept)
//   WVALID/WREADY/WDATA/WSTRB   write-data channel
//   BVALID/BREADY/BRESP         write-response channel
//   wr_fire                     one-cycle write request toward the register file
//   wr_idx/wr_data/wr_strb      captured register index, data and strobes
//   wr_resp                     response chosen by the register file for wr_fire
module axi4_lite_wr_capture
  import amba_axi4_lite_types_pkg::*;
#(
  parameter int SIZE_WORD = 32,
  parameter int SIZE_STRB = SIZE_WORD / 8,
  parameter int SIZE_ADDR = 32
) (
  input  logic                 ACLK,
  input  logic                 ARSTn,
  input  logic                 accept_en,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [SIZE_ADDR-1:0] AWADDR,
  input  logic                 WVALID,
  output logic                 WREADY,
  input  logic [SIZE_WORD-1:0] WDATA,
  input  logic [SIZE_STRB-1:0] WSTRB,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [1:0]           BRESP,
  output logic                 wr_fire,
  output logic [2:0]           wr_idx,
  output logic [SIZE_WORD-1:0] wr_data,
  output logic [SIZE_STRB-1:0] wr_strb,
  input  logic [1:0]           wr_resp
);

  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic [2:0]           aw_idx_q, aw_idx_d;
  logic [SIZE_WORD-1:0] w_data_q, w_data_d;
  logic [SIZE_STRB-1:0] w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  axi4_resp_el          bresp_q, bresp_d;

  // Only the register index is decoded; the rest of the address is don't-care.
  logic unused_awaddr;
  assign unused_awaddr = ^{AWADDR[SIZE_ADDR-1:5], AWADDR[1:0]};

  // A new address or data beat is refused while its slot is occupied or while
  // a response is still waiting on B, so at most one write is in flight.
  assign AWREADY = accept_en && !aw_held_q && !bvalid_q;
  assign WREADY  = accept_en && !w_held_q && !bvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  assign wr_fire = aw_held_q && w_held_q;
  assign wr_idx  = aw_idx_q;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (AWVALID && AWREADY) begin
      aw_held_d = 1'b1;
      aw_idx_d  = AWADDR[4:2];
    end
    if (WVALID && WREADY) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    // Both halves present: the register file acts this cycle, B goes out next.
    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = axi4_resp_el'(wr_resp);
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/amba_axi4_lite_adder_ctrl.sv
// AXI4-Lite slave front-end for a multi-cycle adder core. Holds the operand,
// control, status and result registers, answers reads, and sequences the core
// with a single-cycle start pulse, capturing sum and carry on completion.
//
// Build option: ADDER_CTRL_IRQ_EN adds the irq output, the CTRL.IE bit and a
// write-1-to-clear of STATUS.done.
//
// Ports:
//   ACLK, ARSTn                       clock, asynchronous active-low reset
//   AW*/W*/B*                         AXI4-Lite write channels
//   AR*/R*                            AXI4-Lite read channels
//   add_start                         one-cycle start pulse to the core
//   add_a, add_b                      operands (stable while busy)
//   add_done, add_sum, add_carry      completion pulse and result from the core
//   irq                               (ADDER_CTRL_IRQ_EN only) done && IE, registered
module amba_axi4_lite_adder_ctrl
  import amba_axi4_lite_types_pkg::*;
#(
  parameter int SIZE_WORD = 32,
  parameter int SIZE_STRB = SIZE_WORD / 8,
  parameter int SIZE_ADDR = 32
) (
  input  logic                 ACLK,
  input  logic                 ARSTn,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [SIZE_ADDR-1:0] AWADDR,
  input  logic [2:0]           AWPROT,
  input  logic                 WVALID,
  output logic                 WREADY,
  input  logic [SIZE_WORD-1:0] WDATA,
  input  logic [SIZE_STRB-1:0] WSTRB,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [1:0]           BRESP,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic [SIZE_ADDR-1:0] ARADDR,
  input  logic [2:0]           ARPROT,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [SIZE_WORD-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 add_start,
  output logic [SIZE_WORD-1:0] add_a,
  output logic [SIZE_WORD-1:0] add_b,
  input  logic                 add_done,
  input  logic [SIZE_WORD-1:0] add_sum,
  input  logic                 add_carry
`ifdef ADDER_CTRL_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic                 wr_fire;
  logic [2:0]           wr_idx;
  logic [SIZE_WORD-1:0] wr_data;
  logic [SIZE_STRB-1:0] wr_strb;
  axi4_resp_el          wr_resp;

  logic                 ready_en_q, ready_en_d;
  adder_seq_state_e     state_q, state_d;
  logic                 add_start_q, add_start_d;
  logic [SIZE_WORD-1:0] op_a_q, op_a_d;
  logic [SIZE_WORD-1:0] op_b_q, op_b_d;
  logic [SIZE_WORD-1:0] result_q, result_d;
  logic                 done_q, done_d;
  logic                 carry_q, carry_d;
  logic                 rvalid_q, rvalid_d;
  logic [SIZE_WORD-1:0] rdata_q, rdata_d;
  axi4_resp_el          rresp_q, rresp_d;
`ifdef ADDER_CTRL_IRQ_EN
  logic                 ie_q, ie_d;
  logic                 irq_q, irq_d;
`endif

  logic                 busy;
  logic                 start_req;
  logic [SIZE_WORD-1:0] rd_word;
  axi4_resp_el          rd_resp;

  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, ARADDR[SIZE_ADDR-1:5], ARADDR[1:0]};

  axi4_lite_wr_capture #(
    .SIZE_WORD(SIZE_WORD),
    .SIZE_STRB(SIZE_STRB),
    .SIZE_ADDR(SIZE_ADDR)
  ) u_wr_capture (
    .ACLK     (ACLK),
    .ARSTn    (ARSTn),
    .accept_en(ready_en_q),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .wr_fire  (wr_fire),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .wr_resp  (wr_resp)
  );

  assign busy      = (state_q == C_RUN);
  assign start_req = wr_strb[CTRL_BIT_START] && wr_data[CTRL_BIT_START];

  // READY outputs stay low during reset and for the first cycle after it.
  assign ARREADY   = ready_en_q && !rvalid_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign add_start = add_start_q;
  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
`ifdef ADDER_CTRL_IRQ_EN
  assign irq       = irq_q;
`endif

  // Read decode works on the current register contents, so a read accepted
  // in the same cycle as a write returns the pre-write value.
  always_comb begin
    rd_word = '0;
    rd_resp = OKAY;
    case (ARADDR[4:2])
      ADDER_REG_OP_A:   rd_word = op_a_q;
      ADDER_REG_OP_B:   rd_word = op_b_q;
      ADDER_REG_CTRL: begin
`ifdef ADDER_CTRL_IRQ_EN
        rd_word[CTRL_BIT_IE] = ie_q;
`endif
      end
      ADDER_REG_STATUS: begin
        rd_word[STATUS_BIT_BUSY]  = busy;
        rd_word[STATUS_BIT_DONE]  = done_q;
        rd_word[STATUS_BIT_CARRY] = carry_q;
      end
      ADDER_REG_RESULT: rd_word = result_q;
      default:          rd_resp = SLVERR;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ARVALID && ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_resp;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Register writes and the sequencer. Rejected writes leave every register
  // untouched; operand writes are refused while busy so add_a/add_b stay put.
  always_comb begin
    ready_en_d  = 1'b1;
    state_d     = state_q;
    add_start_d = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    done_d      = done_q;
    carry_d     = carry_q;
    wr_resp     = OKAY;
`ifdef ADDER_CTRL_IRQ_EN
    ie_d        = ie_q;
    irq_d       = done_q && ie_q;
`endif

    if (wr_fire) begin
      case (wr_idx)
        ADDER_REG_OP_A: begin
          if (busy) begin
            wr_resp = SLVERR;
          end else begin
            for (int i = 0; i < SIZE_STRB; i++) begin
              if (wr_strb[i]) op_a_d[i*8 +: 8] = wr_data[i*8 +: 8];
            end
          end
        end
        ADDER_REG_OP_B: begin
          if (busy) begin
            wr_resp = SLVERR;
          end else begin
            for (int i = 0; i < SIZE_STRB; i++) begin
              if (wr_strb[i]) op_b_d[i*8 +: 8] = wr_data[i*8 +: 8];
            end
          end
        end
        ADDER_REG_CTRL: begin
          if (start_req && busy) begin
            wr_resp = SLVERR;
          end else begin
            if (start_req) begin
              state_d     = C_RUN;
              add_start_d = 1'b1;
              done_d      = 1'b0;
            end
`ifdef ADDER_CTRL_IRQ_EN
            if (wr_strb[0]) ie_d = wr_data[CTRL_BIT_IE];
`endif
          end
        end
        ADDER_REG_STATUS: begin
`ifdef ADDER_CTRL_IRQ_EN
          if (wr_strb[0] && wr_data[STATUS_BIT_DONE]) done_d = 1'b0;
`else
          wr_resp = SLVERR;
`endif
        end
        default: wr_resp = SLVERR;
      endcase
    end

    // Completion is only honoured while running; a stray add_done is dropped.
    if (state_q == C_RUN && add_done) begin
      result_d = add_sum;
      carry_d  = add_carry;
      done_d   = 1'b1;
      state_d  = C_IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      ready_en_q  <= 1'b0;
      state_q     <= C_IDLE;
      add_start_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
`ifdef ADDER_CTRL_IRQ_EN
      ie_q        <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      ready_en_q  <= ready_en_d;
      state_q     <= state_d;
      add_start_q <= add_start_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      done_q      <= done_d;
      carry_q     <= carry_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
`ifdef ADDER_CTRL_IRQ_EN
      ie_q        <= ie_d;
      irq_q       <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_amba_axi4_lite_adder_ctrl.sv
// Self-checking bench for amba_axi4_lite_adder_ctrl: a table of single
// register accesses followed by hand-written multi-cycle sequences. A small
// adder-core model answers each add_start with add_done after coreDelay cycles.
module tb_amba_axi4_lite_adder_ctrl;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARSTn = 1'b1;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
  logic        ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0]  WSTRB = '0;
  logic [2:0]  AWPROT = '0, ARPROT = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        add_start;
  logic [31:0] add_a, add_b;
  logic        add_done = 1'b0;
  logic [31:0] add_sum = '0;
  logic        add_carry = 1'b0;
`ifdef ADDER_CTRL_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int doneCount = 0;
  int modelCnt = 0;
  int coreDelay = 4;
  logic [31:0] latchA = '0, latchB = '0;

  amba_axi4_lite_adder_ctrl dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_sum(add_sum), .add_carry(add_carry)
`ifdef ADDER_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Adder-core model: latches operands on add_start, pulses add_done with
  // the 33-bit sum coreDelay cycles later. It is deliberately not reset, so
  // it can deliver a late add_done after the controller has been reset.
  initial begin
    forever begin
      @(negedge ACLK);
      add_done = 1'b0;
      if (modelCnt > 0) begin
        modelCnt--;
        if (modelCnt == 0) begin
          add_done = 1'b1;
          {add_carry, add_sum} = {1'b0, latchA} + {1'b0, latchB};
          doneCount++;
        end
      end
      if (add_start) begin
        startCount++;
        modelCnt = coreDelay;
        latchA = add_a;
        latchB = add_b;
      end
    end
  end

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " AWREADY"}, {31'b0, AWREADY}, 32'd0);
    checkOutput({tag, " WREADY"}, {31'b0, WREADY}, 32'd0);
    checkOutput({tag, " ARREADY"}, {31'b0, ARREADY}, 32'd0);
    checkOutput({tag, " BVALID"}, {31'b0, BVALID}, 32'd0);
    checkOutput({tag, " RVALID"}, {31'b0, RVALID}, 32'd0);
    checkOutput({tag, " BRESP"}, {30'b0, BRESP}, 32'd0);
    checkOutput({tag, " RRESP"}, {30'b0, RRESP}, 32'd0);
    checkOutput({tag, " RDATA"}, RDATA, 32'd0);
    checkOutput({tag, " add_start"}, {31'b0, add_start}, 32'd0);
    checkOutput({tag, " add_a"}, add_a, 32'd0);
    checkOutput({tag, " add_b"}, add_b, 32'd0);
`ifdef ADDER_CTRL_IRQ_EN
    checkOutput({tag, " irq"}, {31'b0, irq}, 32'd0);
`endif
  endtask

  // Full write transaction. AW is offered from cycle awStart, W from wStart.
  // bLat counts negedges from the last handshake to the first BVALID sample.
  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awStart, input int wStart, input int bHold,
                          output logic [1:0] resp, output int bLat,
                          output bit wreadyStuck, output bit bStable);
    int c;
    int lastHs;
    bit awDone;
    bit wDone;
    logic [1:0] firstResp;
    c = 0; lastHs = 0; awDone = 0; wDone = 0;
    resp = 2'b11; bLat = -1; wreadyStuck = 0; bStable = 1;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(awDone && wDone) && c < 100) begin
      AWVALID = !awDone && (c >= awStart);
      WVALID  = !wDone && (c >= wStart);
      if (AWVALID && AWREADY) begin awDone = 1; lastHs = c; end
      if (WVALID && WREADY) begin wDone = 1; lastHs = c; end
      @(negedge ACLK);
      c++;
      if (wDone && !awDone && WREADY) wreadyStuck = 1;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    if (!(awDone && wDone)) return;
    while (!BVALID && c < lastHs + 20) begin
      @(negedge ACLK);
      c++;
    end
    if (BVALID) begin
      bLat = c - lastHs;
      firstResp = BRESP;
      for (int i = 0; i < bHold; i++) begin
        @(negedge ACLK);
        if (!BVALID || BRESP !== firstResp) bStable = 0;
      end
      resp = BRESP;
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
    end
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int c;
    c = 0;
    data = 'x;
    resp = 2'b11;
    ARADDR = addr;
    ARVALID = 1'b1;
    while (!ARREADY && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    if (!ARREADY) begin
      ARVALID = 1'b0;
      return;
    end
    @(negedge ACLK);
    ARVALID = 1'b0;
    c = 0;
    while (!RVALID && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    if (RVALID) begin
      data = RDATA;
      resp = RRESP;
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0]  resp;
    logic [31:0] data;
    int          bLat;
    bit          ws;
    bit          bs;
    if (v.isWrite) begin
      axiWrite(v.addr, v.data, v.strb, 0, 0, 0, resp, bLat, ws, bs);
      checkOutput($sformatf("vec%0d bresp", idx), {30'b0, resp}, {30'b0, v.expResp});
    end else begin
      axiRead(v.addr, data, resp);
      checkOutput($sformatf("vec%0d rdata", idx), data, v.expData);
      checkOutput($sformatf("vec%0d rresp", idx), {30'b0, resp}, {30'b0, v.expResp});
    end
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 100 && doneCount < target; i++) @(negedge ACLK);
    checkOutput("core done seen", doneCount, target);
    @(negedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic writeExpect(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] expResp);
    logic [1:0] resp;
    int         bLat;
    bit         ws;
    bit         bs;
    axiWrite(addr, data, strb, 0, 0, 0, resp, bLat, ws, bs);
    checkOutput({name, " bresp"}, {30'b0, resp}, {30'b0, expResp});
    checkOutput({name, " b latency"}, bLat, 32'd2);
  endtask

  task automatic readExpect(input string name, input logic [31:0] addr, input logic [31:0] expData,
                            input logic [1:0] expResp);
    logic [31:0] data;
    logic [1:0]  resp;
    axiRead(addr, data, resp);
    checkOutput({name, " rdata"}, data, expData);
    checkOutput({name, " rresp"}, {30'b0, resp}, {30'b0, expResp});
  endtask

  initial begin
    logic [1:0] resp;
    int         bLat;
    bit         ws;
    bit         bs;
    int         cnt;

    vecs[0]  = '{1'b1, 32'h00, 32'h1122_3344, 4'hF, RESP_OKAY,   32'h0};
    vecs[1]  = '{1'b1, 32'h00, 32'hAABB_CCDD, 4'h2, RESP_OKAY,   32'h0};
    vecs[2]  = '{1'b0, 32'h00, 32'h0,         4'h0, RESP_OKAY,   32'h1122_CC44};
    vecs[3]  = '{1'b1, 32'h04, 32'h0000_0002, 4'hF, RESP_OKAY,   32'h0};
    vecs[4]  = '{1'b0, 32'h04, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0002};
    vecs[5]  = '{1'b1, 32'h10, 32'h0000_0005, 4'hF, RESP_SLVERR, 32'h0};
    vecs[6]  = '{1'b0, 32'h10, 32'h0,         4'h0, RESP_OKAY,   32'h0};
    vecs[7]  = '{1'b0, 32'h1C, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
    vecs[8]  = '{1'b1, 32'h14, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0};
    vecs[9]  = '{1'b1, 32'h08, 32'h0000_0000, 4'hF, RESP_OKAY,   32'h0};
    vecs[10] = '{1'b1, 32'h08, 32'h0000_0001, 4'h2, RESP_OKAY,   32'h0};
    vecs[11] = '{1'b0, 32'h08, 32'h0,         4'h0, RESP_OKAY,   32'h0};
    vecs[12] = '{1'b0, 32'h0C, 32'h0,         4'h0, RESP_OKAY,   32'h0};
`ifdef ADDER_CTRL_IRQ_EN
    vecs[13] = '{1'b1, 32'h0C, 32'h0000_0002, 4'hF, RESP_OKAY,   32'h0};
`else
    vecs[13] = '{1'b1, 32'h0C, 32'h0000_0002, 4'hF, RESP_SLVERR, 32'h0};
`endif
    vecs[14] = '{1'b0, 32'h100, 32'h0,        4'h0, RESP_OKAY,   32'h1122_CC44};

    #1 ARSTn = 1'b0;
    #11;
    checkResetOutputs("reset");
    @(negedge ACLK);
    ARSTn = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);

    $display("[TB] register table");
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);
    checkOutput("no start from table", startCount, 32'd0);

    $display("[TB] add 0xFFFFFFFF + 2");
    coreDelay = 4;
    writeExpect("opA max", 32'h00, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
    writeExpect("opB two", 32'h04, 32'h0000_0002, 4'hF, RESP_OKAY);
    writeExpect("ctrl start", 32'h08, 32'h0000_0001, 4'hF, RESP_OKAY);
    readExpect("status busy", 32'h0C, 32'h0000_0001, RESP_OKAY);
    checkOutput("add_a held", add_a, 32'hFFFF_FFFF);
    checkOutput("add_b held", add_b, 32'h0000_0002);
    waitDone(1);
    checkOutput("single start pulse", startCount, 32'd1);
    readExpect("status done carry", 32'h0C, 32'h0000_0006, RESP_OKAY);
    readExpect("result", 32'h10, 32'h0000_0001, RESP_OKAY);

    $display("[TB] W leads AW by 3 cycles");
    axiWrite(32'h04, 32'h1234_5678, 4'hF, 3, 0, 0, resp, bLat, ws, bs);
    checkOutput("wlead wready dropped", {31'b0, ws}, 32'd0);
    checkOutput("wlead b latency", bLat, 32'd2);
    checkOutput("wlead bresp", {30'b0, resp}, {30'b0, RESP_OKAY});
    readExpect("wlead opB", 32'h04, 32'h1234_5678, RESP_OKAY);

    $display("[TB] writes while busy");
    coreDelay = 40;
    writeExpect("opA five", 32'h00, 32'h0000_0005, 4'hF, RESP_OKAY);
    writeExpect("opB seven", 32'h04, 32'h0000_0007, 4'hF, RESP_OKAY);
    writeExpect("ctrl start2", 32'h08, 32'h0000_0001, 4'hF, RESP_OKAY);
    writeExpect("start while busy", 32'h08, 32'h0000_0001, 4'hF, RESP_SLVERR);
    writeExpect("opA while busy", 32'h00, 32'h0000_0099, 4'hF, RESP_SLVERR);
    readExpect("opA unchanged", 32'h00, 32'h0000_0005, RESP_OKAY);
    readExpect("status busy keeps carry", 32'h0C, 32'h0000_0005, RESP_OKAY);
    waitDone(2);
    checkOutput("one pulse while busy", startCount, 32'd2);
    readExpect("result 12", 32'h10, 32'h0000_000C, RESP_OKAY);
    readExpect("status done", 32'h0C, 32'h0000_0002, RESP_OKAY);

    $display("[TB] error responses with BREADY held low");
    axiWrite(32'h10, 32'h0000_DEAD, 4'hF, 0, 0, 5, resp, bLat, ws, bs);
    checkOutput("hold b stable", {31'b0, bs}, 32'd1);
    checkOutput("hold bresp", {30'b0, resp}, {30'b0, RESP_SLVERR});
    checkOutput("bvalid after bready", {31'b0, BVALID}, 32'd0);
    readExpect("unmapped read", 32'h1C, 32'h0, RESP_SLVERR);

    $display("[TB] reset while running");
    coreDelay = 10;
    writeExpect("ctrl start3", 32'h08, 32'h0000_0001, 4'hF, RESP_OKAY);
    AWADDR = 32'h00; WDATA = 32'h0000_0077; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    cnt = 0;
    while (!BVALID && cnt < 20) begin
      @(negedge ACLK);
      cnt++;
    end
    checkOutput("pending b before reset", {31'b0, BVALID}, 32'd1);
    checkOutput("starts before reset", startCount, 32'd3);
    #2 ARSTn = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge ACLK);
    @(negedge ACLK);
    ARSTn = 1'b1;
    waitDone(3);
    checkOutput("bvalid dropped", {31'b0, BVALID}, 32'd0);
    readExpect("result after reset", 32'h10, 32'h0, RESP_OKAY);
    readExpect("status after reset", 32'h0C, 32'h0, RESP_OKAY);
    readExpect("opA after reset", 32'h00, 32'h0, RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
